// File: rtl/mode7_pkg.sv
// Shared types and constants for the mode7 parameter-adjust path:
// 16.8 step magnitudes, button direction encoding and repeat FSM states.
package mode7_pkg;

    localparam int FIX_W = 24;

    localparam logic [FIX_W-1:0] STEP_SLOW_DEF = 24'h000100;
    localparam logic [FIX_W-1:0] STEP_FAST_DEF = 24'h000800;

    typedef enum logic [1:0] {
        DIR_NONE  = 2'b00,
        DIR_PLUS  = 2'b01,
        DIR_MINUS = 2'b10
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_SLOW,
        ST_FAST
    } state_t;

    // Counter width able to hold 0..v-1, never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic dir_t decode_dir(input logic plus, input logic minus);
        if (plus && !minus)
            return DIR_PLUS;
        else if (minus && !plus)
            return DIR_MINUS;
        else
            return DIR_NONE;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stable-sample debounce counter
// for one raw pushbutton.
module btn_debounce
    import mode7_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int CW = clog2_min1(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/btn_repeat_ctrl.sv
// Turns the plus/minus pushbuttons into single-cycle step pulses with
// hold-to-repeat and a faster, larger step after sustained holding.
module btn_repeat_ctrl
    import mode7_pkg::*;
#(
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter int               REPEAT_DELAY    = 25000000,
    parameter int               REPEAT_PERIOD   = 5000000,
    parameter int               FAST_AFTER      = 8,
    parameter int               FAST_PERIOD     = 1250000,
    parameter logic [FIX_W-1:0] STEP_SLOW       = STEP_SLOW_DEF,
    parameter logic [FIX_W-1:0] STEP_FAST       = STEP_FAST_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_plus,
    input  logic             btn_minus,
    output logic             inc_pulse,
    output logic             dec_pulse,
    output logic [FIX_W-1:0] step_size,
    output logic             holding
);

    localparam int TMAX_A = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMAX   = (TMAX_A > FAST_PERIOD) ? TMAX_A : FAST_PERIOD;
    localparam int TW     = clog2_min1(TMAX);
    localparam int CW     = clog2_min1(FAST_AFTER + 1);

    localparam logic [TW-1:0] DELAY_LOAD  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LOAD = TW'(REPEAT_PERIOD - 1);
    localparam logic [TW-1:0] FAST_LOAD   = TW'(FAST_PERIOD - 1);
    localparam logic [CW-1:0] FAST_COUNT  = CW'(FAST_AFTER);

    logic          level_plus;
    logic          level_minus;
    dir_t          dir;
    dir_t          held_dir;
    state_t        state;
    logic [TW-1:0] timer;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nx;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_plus (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_plus),
        .level (level_plus)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_minus (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_minus),
        .level (level_minus)
    );

    assign dir      = decode_dir(level_plus, level_minus);
    assign count_nx = count + CW'(1);
    assign holding  = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            held_dir  <= DIR_NONE;
            timer     <= '0;
            count     <= '0;
            inc_pulse <= 1'b0;
            dec_pulse <= 1'b0;
            step_size <= STEP_SLOW;
        end else begin
            inc_pulse <= 1'b0;
            dec_pulse <= 1'b0;
            if (state == ST_IDLE) begin
                step_size <= STEP_SLOW;
                if (dir != DIR_NONE) begin
                    inc_pulse <= (dir == DIR_PLUS);
                    dec_pulse <= (dir == DIR_MINUS);
                    held_dir  <= dir;
                    timer     <= DELAY_LOAD;
                    state     <= ST_DELAY;
                end
            end else if (dir != held_dir) begin
                // Release, opposite button or both pressed: drop the press
                // silently; IDLE picks up any remaining direction next cycle.
                state     <= ST_IDLE;
                held_dir  <= DIR_NONE;
                step_size <= STEP_SLOW;
            end else if (timer != '0) begin
                timer <= timer - TW'(1);
            end else begin
                inc_pulse <= (held_dir == DIR_PLUS);
                dec_pulse <= (held_dir == DIR_MINUS);
                case (state)
                    ST_DELAY: begin
                        count <= CW'(1);
                        if (FAST_AFTER == 1) begin
                            state     <= ST_FAST;
                            timer     <= FAST_LOAD;
                            step_size <= STEP_FAST;
                        end else begin
                            state <= ST_SLOW;
                            timer <= PERIOD_LOAD;
                        end
                    end
                    ST_SLOW: begin
                        count <= count_nx;
                        if (count_nx == FAST_COUNT) begin
                            state     <= ST_FAST;
                            timer     <= FAST_LOAD;
                            step_size <= STEP_FAST;
                        end else begin
                            timer <= PERIOD_LOAD;
                        end
                    end
                    default: timer <= FAST_LOAD;
                endcase
            end
        end
    end

endmodule
